led_trail_fader: RTL and testbench
==================================

// Module: led_trail_fader
// PURPOSE
//  Downstream stage of the LED scanner. Takes the raw 8-bit scan pattern and drives the
//  physical LEDs with PWM, giving each LED a decaying "afterglow" once its input bit
//  drops. The result is the classic scanner comet tail.
//  Sits between the scan-pattern generator output and the board LED pins, clk domain only.
// PARAMETERS
//  N_LEDS       8       number of LED channels
//  PWM_BITS     8       brightness resolution; MAX = 2**PWM_BITS-1
//  DECAY_DIV    250000  clk cycles per decay tick (>=2); sim uses 4
//  DECAY_SHIFT  2       per-tick decay = max(level>>DECAY_SHIFT, 1)
// PORTS
//  clk      in   1        system clock, all logic on posedge
//  rst      in   1        synchronous, active-high reset
//  led_in   in   N_LEDS   raw scan pattern, 1 = LED lit
//  led_out  out  N_LEDS   PWM-modulated LED drive, registered
//  tick     out  1        1-cycle pulse on every decay tick (debug/observe)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all levels 0, prescaler 0, PWM counter 0, led_out=0, tick=0.
//    Holds while rst=1. Reset mid-fade discards all afterglow immediately.
//  - Prescaler: counts 0..DECAY_DIV-1 and wraps. tick=1 for the one cycle where the count
//    equals DECAY_DIV-1. The first tick after rst deasserts occurs DECAY_DIV cycles later.
//  - Per channel i, level[i] is PWM_BITS wide and updates each cycle, in priority order:
//    1. led_in[i]=1 -> level=MAX. This wins over a simultaneous tick.
//    2. tick and level>0 -> level = level - max(level>>DECAY_SHIFT, 1). Never underflows.
//    3. Otherwise level holds. 0 is sticky until led_in reasserts.
//  - PWM counter: counts 0..MAX-1 (period MAX cycles) and wraps to 0.
//  - Output: led_out[i] <= (duty[i] > pwm_cnt). duty=MAX gives 100%, duty=0 gives 0%.
//    Over any aligned MAX-cycle window the high count equals duty, if duty is constant.
//  - Latency: led_in edge at cycle t -> level updated at t+1 -> led_out reflects it at t+2.
//  - All channels share the prescaler and PWM counter, so they are phase-aligned.
//  - No handshake. led_in is sampled every cycle, and a 1-cycle pulse is enough to load MAX.
// CONFIGURATION
//  - LED_GAMMA_EN defined:
//    duty = (level*level + level) >> PWM_BITS, using a 2*PWM_BITS-bit intermediate.
//    Examples: 255->255, 128->64, 1->0, 0->0. Adds no extra latency (combinational
//    before the output register).
//  - LED_GAMMA_EN undefined: duty = level (linear).
// STRUCTURE
//  - Shared package/header led_pkg: N_LEDS default, PWM_BITS default, LED_MAX constant,
//    level width typedef. The scan generator uses the same N_LEDS.
//  - One natural sub-module: led_fade_channel (one level register, decay, optional gamma,
//    PWM compare). Instantiate it N_LEDS times via generate.
//  - Top level owns the prescaler and PWM counter and broadcasts tick and pwm_cnt.
// TESTING  (PWM_BITS=8, DECAY_DIV=4, DECAY_SHIFT=2 unless stated)
//  1. Assert rst for 3 cycles with led_in=8'hFF -> led_out=0, tick=0 throughout;
//     first tick 4 cycles after release.
//  2. Hold led_in=8'h01 -> from cycle 2 onward led_out[0]=1 every cycle and
//     led_out[7:1]=0 for all cycles.
//  3. One-cycle pulse on led_in[3] -> level sequence across ticks: 255,192,144,108,81,61,...
//     Every value is monotonic and reaches 0. The measured high count per 255-cycle window
//     equals level. Set DECAY_DIV=1000 for this measurement.
//  4. led_in[5]=1 in the same cycle as tick, with level=100 -> level=255 next cycle
//     (load beats decay).
//  5. Preload level=3 with no input -> ticks give 2,1,0, then 0 stays at 0.
//     led_out stays 0 at level 0 for a full PWM period.
//  6. Assert rst mid-fade (level=144) -> next cycle level=0, led_out=0.
//     With LED_GAMMA_EN, a constant level of 128 -> 64 highs per 255 cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED scanner chain.
// The scan-pattern generator and the trail fader both size themselves from N_LEDS_DEF.
package led_pkg;

  localparam int N_LEDS_DEF   = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int LED_MAX      = (1 << PWM_BITS_DEF) - 1;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel of the trail fader: brightness level register, tick-driven decay,
// optional gamma shaping and the PWM compare feeding a registered LED output.
// Build option: LED_GAMMA_EN selects duty = (level*level + level) >> PWM_BITS,
// otherwise duty follows level linearly.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
  localparam logic [PWM_BITS-1:0] ONE_LEVEL = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] decay_step;
  logic [PWM_BITS-1:0] duty;

  // Decay step is a fraction of the current level but never less than one, so small
  // levels still reach zero instead of stalling.
  always_comb begin
    decay_step = level >> DECAY_SHIFT;
    if (decay_step == '0) begin
      decay_step = ONE_LEVEL;
    end
  end

  // A lit input always reloads full brightness, even on a tick; otherwise fade on ticks.
  // Since decay_step <= level whenever level > 0, the subtraction cannot wrap.
  always_comb begin
    level_next = level;
    if (load) begin
      level_next = MAX_LEVEL;
    end else if (tick && (level != '0)) begin
      level_next = level - decay_step;
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_wide;
  logic [2*PWM_BITS-1:0] gamma_prod;

  // Approximate square-law perceived brightness; keeps full scale at full scale.
  always_comb begin
    level_wide = {{PWM_BITS{1'b0}}, level};
    gamma_prod = (level_wide * level_wide) + level_wide;
    duty       = gamma_prod[2*PWM_BITS-1:PWM_BITS];
  end
`else
  // Linear brightness: duty is the level itself.
  always_comb begin
    duty = level;
  end
`endif

  // Level state and registered PWM output; reset drops any afterglow at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      level <= level_next;
      led   <= (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_fader.sv
// Trail fader between the scan-pattern generator and the board LED pins.
// Owns the decay prescaler and the PWM counter and broadcasts both to every channel,
// so all LEDs are phase-aligned. Build option LED_GAMMA_EN enables gamma shaping.
module led_trail_fader
  import led_pkg::*;
#(
  parameter int N_LEDS      = N_LEDS_DEF,
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DECAY_DIV   = 250000,
  parameter int DECAY_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              tick
);

  localparam int PRE_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Decay tick is high for exactly the last prescaler count of each period.
  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: 0..DECAY_DIV-1, wrapping, sets the fade speed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // PWM counter: 0..MAX-1 so a period is MAX cycles and duty MAX means always on.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : gen_ch
    led_fade_channel #(
      .PWM_BITS    (PWM_BITS),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (led_in[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .led     (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader. Instance A uses a fast decay (DECAY_DIV=4) for
// reset, latency, fade sequence and priority checks; instance B uses DECAY_DIV=1000 so
// each level stays constant long enough to count highs over a full PWM period.
module tb_led_trail_fader;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in_a;
  logic [7:0] led_in_b;
  logic [7:0] led_out_a;
  logic [7:0] led_out_b;
  logic       tick_a;
  logic       tick_b;

  int num_checks = 0;
  int num_errors = 0;

  level_t lvl_a3;
  level_t lvl_a5;
  level_t lvl_b3;

  // Expected fade of a single pulse with DECAY_SHIFT=2, one entry per tick.
  int fade_seq [21] = '{255, 192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

  // Expected highs per 255-cycle window for levels 255, 192, 144, 108, 81.
`ifdef LED_GAMMA_EN
  int window_seq [5] = '{255, 144, 81, 45, 25};
`else
  int window_seq [5] = '{255, 192, 144, 108, 81};
`endif

  // Free-running clock.
  always #5 clk = ~clk;

  assign lvl_a3 = dut_a.gen_ch[3].u_ch.level;
  assign lvl_a5 = dut_a.gen_ch[5].u_ch.level;
  assign lvl_b3 = dut_b.gen_ch[3].u_ch.level;

  led_trail_fader #(
    .N_LEDS      (8),
    .PWM_BITS    (8),
    .DECAY_DIV   (4),
    .DECAY_SHIFT (2)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in_a),
    .led_out (led_out_a),
    .tick    (tick_a)
  );

  led_trail_fader #(
    .N_LEDS      (8),
    .PWM_BITS    (8),
    .DECAY_DIV   (1000),
    .DECAY_SHIFT (2)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .led_in  (led_in_b),
    .led_out (led_out_b),
    .tick    (tick_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs, clock one edge, and leave outputs ready for sampling.
  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] b);
    rst      = r;
    led_in_a = a;
    led_in_b = b;
    step();
  endtask

  task automatic waitTickA();
    int n = 0;
    while (!tick_a && n < 100) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      n++;
    end
    if (!tick_a) checkOutput("tick_a_timeout", 0, 1);
  endtask

  task automatic waitTickB();
    int n = 0;
    while (!tick_b && n < 1100) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      n++;
    end
    if (!tick_b) checkOutput("tick_b_timeout", 0, 1);
  endtask

  task automatic countHighsB(output int highs);
    highs = 0;
    for (int k = 0; k < 255; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      if (led_out_b[3]) highs++;
    end
  endtask

  initial begin
    int highs;
    int tick_exp [4] = '{0, 0, 1, 0};

    $display("[TB] start");

    // Reset held with all inputs lit: outputs stay dark.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'hFF, 8'hFF);
      checkOutput("rst_led_out_a", led_out_a, 0);
      checkOutput("rst_tick_a", tick_a, 0);
      checkOutput("rst_led_out_b", led_out_b, 0);
    end

    // Prescaler timing after release.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("tick_after_release_%0d", k + 1), tick_a, tick_exp[k]);
    end

    // Held input on channel 0: one-cycle load, one more for the output register.
    applyStimulus(1'b0, 8'h01, 8'h00);
    checkOutput("hold_latency_first", led_out_a, 0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 8'h01, 8'h00);
      checkOutput($sformatf("hold_led0_%0d", k), led_out_a, 8'h01);
    end

    // Single pulse on channel 3 fades through the expected sequence to zero.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h08, 8'h00);
    checkOutput("pulse_load", lvl_a3, fade_seq[0]);
    for (int k = 1; k < 21; k++) begin
      waitTickA();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("fade_step_%0d", k), lvl_a3, fade_seq[k]);
    end
    for (int k = 0; k < 3; k++) begin
      waitTickA();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("zero_sticky_%0d", k), lvl_a3, 0);
    end
    highs = 0;
    for (int k = 0; k < 255; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      if (led_out_a[3]) highs++;
    end
    checkOutput("zero_level_dark", highs, 0);

    // Load wins over a simultaneous tick on channel 5.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 2; k++) begin
      waitTickA();
      applyStimulus(1'b0, 8'h00, 8'h00);
    end
    checkOutput("ch5_before_reload", lvl_a5, 144);
    waitTickA();
    checkOutput("tick_at_reload", tick_a, 1);
    applyStimulus(1'b0, 8'h20, 8'h00);
    checkOutput("load_beats_tick", lvl_a5, 255);

    // Reset in the middle of a fade clears level and output.
    applyStimulus(1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'h08, 8'h00);
    for (int k = 0; k < 2; k++) begin
      waitTickA();
      applyStimulus(1'b0, 8'h00, 8'h00);
    end
    checkOutput("mid_fade_level", lvl_a3, 144);
    applyStimulus(1'b1, 8'h00, 8'h00);
    checkOutput("mid_fade_rst_level", lvl_a3, 0);
    checkOutput("mid_fade_rst_out", led_out_a, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("after_rst_dark_%0d", k), led_out_a, 0);
    end

    // Slow instance: highs per PWM period track the level at each fade step.
    waitTickB();
    applyStimulus(1'b0, 8'h00, 8'h08);
    checkOutput("b_load_on_tick", lvl_b3, 255);
    applyStimulus(1'b0, 8'h00, 8'h00);
    countHighsB(highs);
    checkOutput("b_window_0", highs, window_seq[0]);
    for (int j = 1; j < 5; j++) begin
      waitTickB();
      applyStimulus(1'b0, 8'h00, 8'h00);
      checkOutput($sformatf("b_level_%0d", j), lvl_b3, fade_seq[j]);
      applyStimulus(1'b0, 8'h00, 8'h00);
      countHighsB(highs);
      checkOutput($sformatf("b_window_%0d", j), highs, window_seq[j]);
    end

    checkOutput("max_const", LED_MAX, 255);
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
